uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames, clocked by the 16x oversampling `tick` from the baud generator. Synchronizes the external `rx_pin`, detects start bits, majority-votes each bit near mid-bit, and delivers each received byte with a one-cycle valid pulse. Framing errors are flagged with their own pulse. Sits between the board RX pin and the UART register/FIFO layer, in the receive direction of the UART link.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `rx_pin` before any use; legal range 2..4.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  16x-baud enable pulse, one `clk` wide.
- `rx_pin`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last good byte received, LSB first on the wire.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a new byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: chain of `SYNC_STAGES` flops; reset value 1. `rx_s` denotes the last stage; `rx_s_d` is `rx_s` delayed one `clk`.
- Counters: `tick_cnt` is 4 bits and advances only on `tick`. `bit_cnt` is 3 bits. `shift_reg` is 8 bits.
- Sampling: on a `tick` where `tick_cnt` is 7, 8 or 9 before increment, latch `rx_s` into sample s0, s1 or s2. The vote is 1 when at least 2 of the 3 samples are 1.
- FSM states:
  - IDLE: `rx_busy`=0. On `rx_s_d`=1 and `rx_s`=0, a synchronized falling edge, go to START and set `tick_cnt`=0. A line that is already low never triggers; a falling edge is required.
  - START: on the tick with `tick_cnt`==9, if the vote is 1 this is a false start: go to IDLE with no output pulse. Otherwise continue. On the tick with `tick_cnt`==15, go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - DATA: on the tick with `tick_cnt`==15, set `shift_reg` = {vote, `shift_reg`[7:1]} and `tick_cnt`=0. If `bit_cnt`==7, go to STOP; otherwise increment `bit_cnt`.
  - STOP: on the tick with `tick_cnt`==9, evaluate the vote and go to IDLE.
    - Vote 1: load `rx_data` from `shift_reg` and pulse `rx_valid`.
    - Vote 0: pulse `frame_err`; `rx_data` is unchanged.
- Leaving STOP at mid-bit gives 6/16 bit of slack for resynchronizing to the next start edge.
- A falling edge seen by IDLE during the remainder of the stop bit is impossible; a line still low from a break needs a rising edge and then a new falling edge.
- `tick` arriving on consecutive `clk` cycles is legal. Each tick counts once.
- Overrun is not detected here; the consumer must take `rx_data` within one frame time.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `rx_busy`=0.
  - State IDLE; all counters 0; synchronizer flops 1.
- Reset is asynchronous and may be asserted mid-frame. It aborts the frame with no pulse, and the next frame must be received correctly.
- All outputs are registered.
- `rx_valid`/`frame_err` rise in the `clk` cycle after the STOP tick where `tick_cnt`==9, and last exactly one cycle. They are mutually exclusive.
- `rx_data` changes only in the same cycle `rx_valid` rises, and holds until the next good byte.
- Detection latency: IDLE leaves in the `clk` cycle after the pin edge reaches `rx_s`, which is `SYNC_STAGES`+1 cycles after the pin edge.
- Frame latency: 16 ticks (START) + 128 ticks (DATA) + 10 ticks (STOP) = 154 ticks from the START entry to the result pulse.
- `rx_busy` rises with the START entry and falls with the return to IDLE.

## Test plan
- 0xA5 sent at exactly 16 ticks/bit -> one `rx_valid` pulse, `rx_data`=0xA5, `frame_err` never high, `rx_busy` high for 154 ticks.
- 0x00 and 0xFF sent back-to-back with a 1-bit stop and no idle gap -> two `rx_valid` pulses, bytes 0x00 then 0xFF.
- 3-tick low glitch on an idle line -> START entered, return to IDLE at `tick_cnt`==9, no `rx_valid`/`frame_err`, `rx_data` unchanged.
- 0x3C sent with stop bit forced low, then the line returned high, then 0x81 sent -> `frame_err` pulse only for the first frame, `rx_data` stays at its prior value; the next frame yields `rx_valid` with `rx_data`=0x81.
- 0x55 with a 1-tick inverted spike at sample 8 of every bit -> `rx_data`=0x55, because the majority vote rejects the spike.
- `reset_n` asserted during DATA bit 4 of 0xF0, then released, then 0x81 sent -> no pulse for the aborted frame, all outputs at reset values, then `rx_valid` with `rx_data`=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver on a 16x oversampling tick, 3-sample majority vote per bit
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rx_s;
  logic                   rx_s_prev_q;

  state_t     state_q;
  logic [3:0] tick_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       s0_q, s1_q, s2_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       frame_err_q;
  logic       rx_busy_q;
  logic       vote_mid;
  logic       vote_end;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_pin};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '1;
      rx_s_prev_q <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      rx_s_prev_q <= rx_s;
    end
  end

  // At tick_cnt 9 the third sample is still being latched, so use the live rx_s in its place.
  assign vote_mid = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign vote_end = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (tick && (state_q != IDLE)) begin
        tick_cnt_q <= tick_cnt_q + 4'd1;
        case (tick_cnt_q)
          4'd7:    s0_q <= rx_s;
          4'd8:    s1_q <= rx_s;
          4'd9:    s2_q <= rx_s;
          default: ;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (rx_s_prev_q && !rx_s) begin
            state_q    <= START;
            tick_cnt_q <= 4'd0;
            rx_busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if ((tick_cnt_q == 4'd9) && vote_mid) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else if (tick_cnt_q == 4'd15) begin
              state_q    <= DATA;
              tick_cnt_q <= 4'd0;
              bit_cnt_q  <= 3'd0;
            end
          end
        end
        DATA: begin
          if (tick && (tick_cnt_q == 4'd15)) begin
            shift_q    <= {vote_end, shift_q[7:1]};
            tick_cnt_q <= 4'd0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick && (tick_cnt_q == 4'd9)) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
            if (vote_mid) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rx_pin    (rx_pin),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  exp_t       push_e;
  int         n_checks = 0;
  int         n_pass = 0;
  int         busy_ticks = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick_once();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    if (rx_busy) busy_ticks++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) tick_once();
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop, input bit spike, input int nticks);
    for (int t = 0; t < nticks; t++) begin
      int   b;
      int   j;
      logic v;
      b = t / 16;
      j = t % 16;
      if (b == 0) v = 1'b0;
      else if (b == 9) v = stop;
      else v = d[b-1];
      rx_pin = (spike && j == 8) ? ~v : v;
      tick_once();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit spike);
    if (stop) begin
      push_e.is_err = 1'b0;
      push_e.data   = d;
      last_good     = d;
    end else begin
      push_e.is_err = 1'b1;
      push_e.data   = last_good;
    end
    sb.push_back(push_e);
    send_bits(d, stop, spike, 160);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      check("mutex", {31'd0, rx_valid & frame_err}, 0);
      check("pulse_width", {31'd0, prev_valid | prev_ferr}, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
      end
    end else if (reset_n && rx_data != prev_data) begin
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, prev_data});
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_data  = rx_data;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
    check({tag, "_rx_busy"}, {31'd0, rx_busy}, 0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    idle(4);

    busy_ticks = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("a5_drain");
    check("a5_busy_ticks", busy_ticks, 154);

    idle(4);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain("b2b_drain");

    idle(4);
    busy_ticks = 0;
    rx_pin = 1'b0;
    repeat (3) tick_once();
    rx_pin = 1'b1;
    repeat (20) tick_once();
    check("glitch_busy_ticks", busy_ticks, 10);
    drain("glitch_drain");
    check("glitch_rx_data", {24'd0, rx_data}, 32'h0000_00FF);

    idle(4);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h81, 1'b1, 1'b0);
    drain("ferr_drain");

    idle(4);
    send_frame(8'h55, 1'b1, 1'b1);
    drain("spike_drain");

    idle(4);
    send_bits(8'hF0, 1'b1, 1'b0, 16 + 4 * 16 + 8);
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    last_good = 8'h00;
    rx_pin = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    idle(8);
    send_frame(8'h81, 1'b1, 1'b0);
    drain("after_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
